control: RTL and testbench
==========================

# control

- Moore-style multicycle controller that sequences the RV32I datapath: fetch, decode, execute, memory and writeback for every RV32I base instruction except FENCE/ECALL/EBREAK/CSR.
- Sits beside the datapath. It consumes the decoded IR fields, `br_en` and `mem_address`, and drives all datapath load enables, mux selects and ALU/CMP ops, plus the memory read/write handshake.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `opcode`  in  7  `rv32i_opcode` from IR.
- `funct3`  in  3  IR funct3.
- `funct7`  in  7  IR funct7.
- `br_en`  in  1  CMP result.
- `rs1`, `rs2`  in  5 each  IR register fields (RVFI only, unused in logic).
- `mem_address`  in  32  MAR output, for byte enables.
- `mem_resp`  in  1  one-cycle memory completion pulse.
- `load_pc`, `load_ir`, `load_regfile`, `load_mar`, `load_mdr`, `load_data_out`  out  1 each  register loads.
- `pcmux_sel`  out  2  0 pc+4, 1 alu_out, 2 alu_out with bit0 cleared.
- `alumux1_sel`  out  1  0 rs1, 1 pc.
- `alumux2_sel`  out  3  0 i_imm, 1 u_imm, 2 b_imm, 3 s_imm, 4 j_imm, 5 rs2.
- `regfilemux_sel`  out  4  0 alu, 1 br_en, 2 u_imm, 3 mdr, 4 pc+4, 5 lh, 6 lhu, 7 lb, 8 lbu.
- `marmux_sel`  out  1  0 pc, 1 alu_out.
- `cmpmux_sel`  out  1  0 rs2, 1 i_imm.
- `aluop`  out  3  `alu_ops`.
- `cmpop`  out  3  `branch_funct3_t`.
- `mem_read`, `mem_write`  out  1 each  memory requests.
- `mem_byte_enable`  out  4  store lane mask.

## Operation
- Defaults in every state: all loads, `mem_read` and `mem_write` are 0; all selects are 0; `aluop` = add; `cmpop` = funct3; `mem_byte_enable` = 4'b1111.
- Fetch sequence:
  - FETCH1: `load_mar`, marmux=pc.
  - FETCH2: `mem_read`, `load_mdr`; stay until `mem_resp`.
  - FETCH3: `load_ir`.
  - DECODE: no outputs; dispatch on `opcode`.
- Execute states:
  - LUI: regfilemux=2, `load_regfile`, `load_pc`.
  - AUIPC: alumux1=pc, alumux2=u_imm, add, `load_regfile`, `load_pc`.
  - IMM:
    - slti/sltiu: cmpmux=i_imm, cmpop blt/bltu, regfilemux=1.
    - srai (funct7[5]=1): aluop sra.
    - others: aluop = funct3.
    - All: `load_regfile`, `load_pc`.
  - REG:
    - alumux2=rs2.
    - add/sub and srl/sra select on funct7[5].
    - slt/sltu: cmpmux=rs2, regfilemux=1.
    - All: `load_regfile`, `load_pc`.
  - BR: alumux1=pc, alumux2=b_imm, add, `load_pc`; pcmux = `br_en` ? 1 : 0.
  - JAL: regfilemux=4, alumux1=pc, alumux2=j_imm, pcmux=1, `load_regfile`, `load_pc`.
  - JALR: regfilemux=4, alumux2=i_imm, pcmux=2, `load_regfile`, `load_pc`.
- Load path:
  - CALC_LD: alumux2=i_imm, marmux=1, `load_mar`.
  - LD1: `mem_read`, `load_mdr`; hold until `mem_resp`.
  - LD2: regfilemux per funct3 (lw 3, lh 5, lhu 6, lb 7, lbu 8), `load_regfile`, `load_pc`.
- Store path:
  - CALC_ST: alumux2=s_imm, marmux=1, `load_mar`, `load_data_out`.
  - ST1: `mem_write`; hold until `mem_resp`. Byte enables: sb 4'b0001 << addr[1:0]; sh 4'b0011 << {addr[1],1'b0}; sw 4'b1111.
  - ST2: `load_pc`.
- Every execute/writeback state returns to FETCH1.
- Unknown opcode in DECODE: go to FETCH1 with no loads. PC is not advanced; this is the documented halt-on-illegal behaviour.

## Timing
- Reset (`rst`=0): state=FETCH1 immediately. All outputs take their default values while held; the first cycle after release is FETCH1.
- Reset mid-transaction: the request is abandoned immediately. `mem_read`/`mem_write` drop to 0 asynchronously and no load fires.
- `mem_read`/`mem_write` remain asserted continuously until the cycle in which `mem_resp`=1. The transition happens on that edge.
- A `mem_resp` pulse outside FETCH2/LD1/ST1 is ignored.
- Cycle counts with 1-cycle memory:
  - ALU, LUI, AUIPC, branch, JAL, JALR: 5 cycles.
  - Loads: 7 cycles.
  - Stores: 7 cycles.
  - Each extra memory wait cycle adds 1.
- Writes to x0 are issued normally; regfile discards them.

## Test plan
- Reset held 3 cycles, released → FETCH1: `load_mar`=1, marmux=0, all other loads and memory requests 0.
- ADDI x1,x0,5 (0x00500093) with immediate `mem_resp` → 5 cycles; IMM state shows aluop add, alumux2=0, `load_regfile`=`load_pc`=1.
- BEQ with `br_en`=1 → pcmux=1, alumux1=1, alumux2=2. With `br_en`=0 → pcmux=0. `load_regfile`=0 in both cases.
- LW, `mem_resp` delayed 3 cycles in LD1 → `mem_read` high 3 cycles; LD2 regfilemux=3; total 9 cycles.
- SB with `mem_address`[1:0]=2 → ST1 `mem_write`=1, `mem_byte_enable`=4'b0100. SH with addr[1]=1 → 4'b1100.
- `rst` pulsed low during LD1 → `mem_read` falls the same cycle, no `load_regfile`; restart at FETCH1.

Source files
------------

// File: rtl/control.sv
// Multicycle RV32I controller. A Moore FSM walks every instruction through
// fetch, decode, execute and (for loads/stores) memory, driving the
// datapath load enables, mux selects, ALU/CMP ops and the memory request.
//
// Memory handshake: mem_read/mem_write are held high for every cycle the FSM
// sits in a memory state (FETCH2, LD1, ST1). The access completes in the
// cycle where mem_resp=1, and the FSM leaves the memory state on that edge.
// mem_resp seen in any other state has no effect. Reset drops any request at
// once because all outputs are forced to their defaults while rst is low.
module control (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        br_en,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] mem_address,
  input  logic        mem_resp,
  output logic        load_pc,
  output logic        load_ir,
  output logic        load_regfile,
  output logic        load_mar,
  output logic        load_mdr,
  output logic        load_data_out,
  output logic [1:0]  pcmux_sel,
  output logic        alumux1_sel,
  output logic [2:0]  alumux2_sel,
  output logic [3:0]  regfilemux_sel,
  output logic        marmux_sel,
  output logic        cmpmux_sel,
  output logic [2:0]  aluop,
  output logic [2:0]  cmpop,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable
);

  // RV32I major opcodes
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  // ALU operations that do not coincide with funct3
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SRA  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_SRL  = 3'b101;

  // Comparator operations used for slt/sltu
  localparam logic [2:0] CMP_BLT  = 3'b100;
  localparam logic [2:0] CMP_BLTU = 3'b110;

  // FSM states
  localparam logic [4:0] S_FETCH1  = 5'd0;
  localparam logic [4:0] S_FETCH2  = 5'd1;
  localparam logic [4:0] S_FETCH3  = 5'd2;
  localparam logic [4:0] S_DECODE  = 5'd3;
  localparam logic [4:0] S_LUI     = 5'd4;
  localparam logic [4:0] S_AUIPC   = 5'd5;
  localparam logic [4:0] S_IMM     = 5'd6;
  localparam logic [4:0] S_REG     = 5'd7;
  localparam logic [4:0] S_BR      = 5'd8;
  localparam logic [4:0] S_JAL     = 5'd9;
  localparam logic [4:0] S_JALR    = 5'd10;
  localparam logic [4:0] S_CALC_LD = 5'd11;
  localparam logic [4:0] S_LD1     = 5'd12;
  localparam logic [4:0] S_LD2     = 5'd13;
  localparam logic [4:0] S_CALC_ST = 5'd14;
  localparam logic [4:0] S_ST1     = 5'd15;
  localparam logic [4:0] S_ST2     = 5'd16;

  logic [4:0] state_q;
  logic [4:0] state_d;

  // Register fields and upper address bits are only carried for tracing.
  logic unused_fields;
  assign unused_fields = ^{rs1, rs2, funct7[6], funct7[4:0], mem_address[31:2]};

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH1:  state_d = S_FETCH2;
      S_FETCH2:  if (mem_resp) state_d = S_FETCH3;
      S_FETCH3:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LUI:   state_d = S_LUI;
          OP_AUIPC: state_d = S_AUIPC;
          OP_JAL:   state_d = S_JAL;
          OP_JALR:  state_d = S_JALR;
          OP_BR:    state_d = S_BR;
          OP_LOAD:  state_d = S_CALC_LD;
          OP_STORE: state_d = S_CALC_ST;
          OP_IMM:   state_d = S_IMM;
          OP_REG:   state_d = S_REG;
          // Illegal opcode: refetch without advancing PC (halt in place).
          default:  state_d = S_FETCH1;
        endcase
      end
      S_CALC_LD: state_d = S_LD1;
      S_LD1:     if (mem_resp) state_d = S_LD2;
      S_CALC_ST: state_d = S_ST1;
      S_ST1:     if (mem_resp) state_d = S_ST2;
      default:   state_d = S_FETCH1;
    endcase
  end

  // State register, asynchronously returned to FETCH1 by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH1;
    else      state_q <= state_d;
  end

  // Moore outputs; forced to defaults while reset is asserted
  always_comb begin
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_data_out   = 1'b0;
    pcmux_sel       = 2'd0;
    alumux1_sel     = 1'b0;
    alumux2_sel     = 3'd0;
    regfilemux_sel  = 4'd0;
    marmux_sel      = 1'b0;
    cmpmux_sel      = 1'b0;
    aluop           = ALU_ADD;
    cmpop           = funct3;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'b1111;
    if (rst) begin
      case (state_q)
        S_FETCH1: load_mar = 1'b1;
        S_FETCH2: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
        end
        S_FETCH3: load_ir = 1'b1;
        S_LUI: begin
          regfilemux_sel = 4'd2;
          load_regfile   = 1'b1;
          load_pc        = 1'b1;
        end
        S_AUIPC: begin
          alumux1_sel  = 1'b1;
          alumux2_sel  = 3'd1;
          load_regfile = 1'b1;
          load_pc      = 1'b1;
        end
        S_IMM: begin
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          case (funct3)
            3'b010: begin
              cmpmux_sel     = 1'b1;
              cmpop          = CMP_BLT;
              regfilemux_sel = 4'd1;
            end
            3'b011: begin
              cmpmux_sel     = 1'b1;
              cmpop          = CMP_BLTU;
              regfilemux_sel = 4'd1;
            end
            3'b101:  aluop = funct7[5] ? ALU_SRA : ALU_SRL;
            default: aluop = funct3;
          endcase
        end
        S_REG: begin
          alumux2_sel  = 3'd5;
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          case (funct3)
            3'b000:  aluop = funct7[5] ? ALU_SUB : ALU_ADD;
            3'b101:  aluop = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b010: begin
              cmpop          = CMP_BLT;
              regfilemux_sel = 4'd1;
            end
            3'b011: begin
              cmpop          = CMP_BLTU;
              regfilemux_sel = 4'd1;
            end
            default: aluop = funct3;
          endcase
        end
        S_BR: begin
          alumux1_sel = 1'b1;
          alumux2_sel = 3'd2;
          load_pc     = 1'b1;
          pcmux_sel   = br_en ? 2'd1 : 2'd0;
        end
        S_JAL: begin
          regfilemux_sel = 4'd4;
          alumux1_sel    = 1'b1;
          alumux2_sel    = 3'd4;
          pcmux_sel      = 2'd1;
          load_regfile   = 1'b1;
          load_pc        = 1'b1;
        end
        S_JALR: begin
          regfilemux_sel = 4'd4;
          pcmux_sel      = 2'd2;
          load_regfile   = 1'b1;
          load_pc        = 1'b1;
        end
        S_CALC_LD: begin
          marmux_sel = 1'b1;
          load_mar   = 1'b1;
        end
        S_LD1: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
        end
        S_LD2: begin
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          case (funct3)
            3'b000:  regfilemux_sel = 4'd7;
            3'b001:  regfilemux_sel = 4'd5;
            3'b100:  regfilemux_sel = 4'd8;
            3'b101:  regfilemux_sel = 4'd6;
            default: regfilemux_sel = 4'd3;
          endcase
        end
        S_CALC_ST: begin
          alumux2_sel   = 3'd3;
          marmux_sel    = 1'b1;
          load_mar      = 1'b1;
          load_data_out = 1'b1;
        end
        S_ST1: begin
          mem_write = 1'b1;
          case (funct3)
            3'b000:  mem_byte_enable = 4'b0001 << mem_address[1:0];
            3'b001:  mem_byte_enable = 4'b0011 << {mem_address[1], 1'b0};
            default: mem_byte_enable = 4'b1111;
          endcase
        end
        S_ST2: load_pc = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control.sv
// Bench for the RV32I multicycle controller. An instruction table describes
// each mnemonic's meaning; a reference model expands it into the expected
// per-cycle control word sequence, which is checked cycle by cycle.
module tb_control;

  typedef struct packed {
    logic       ld_pc;
    logic       ld_ir;
    logic       ld_rf;
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_dout;
    logic [1:0] pcmux;
    logic       am1;
    logic [2:0] am2;
    logic [3:0] rfmux;
    logic       marmux;
    logic       cmpmux;
    logic [2:0] aluop;
    logic [2:0] cmpop;
    logic       mrd;
    logic       mwr;
    logic [3:0] mbe;
  } ctl_t;

  localparam int W = 30;

  localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BR = 4,
                 K_LD = 5, K_ST = 6, K_IALU = 7, K_ISLT = 8, K_RALU = 9,
                 K_RSLT = 10, K_ILL = 11;

  localparam logic [2:0] A_ADD = 3'd0, A_SLL = 3'd1, A_SRA = 3'd2, A_SUB = 3'd3,
                         A_XOR = 3'd4, A_SRL = 3'd5, A_OR = 3'd6, A_AND = 3'd7;
  localparam logic [2:0] C_BLT = 3'd4, C_BLTU = 3'd6;

  typedef struct {
    string      name;
    int         kind;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] aux;   // ALU op, compare op, load writeback select or store byte count
    bit         free;  // funct7 is immediate bits and may be anything
  } row_t;

  row_t rows[$];

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        br_en;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] mem_address;
  logic        mem_resp;
  logic        load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
  logic [1:0]  pcmux_sel;
  logic        alumux1_sel;
  logic [2:0]  alumux2_sel;
  logic [3:0]  regfilemux_sel;
  logic        marmux_sel;
  logic        cmpmux_sel;
  logic [2:0]  aluop;
  logic [2:0]  cmpop;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byte_enable;

  logic [W-1:0] out_v;
  logic [W-1:0] exp_q[$];
  logic         resp_q[$];
  int           checks;
  int           failures;

  control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .rs1(rs1), .rs2(rs2), .mem_address(mem_address),
    .mem_resp(mem_resp), .load_pc(load_pc), .load_ir(load_ir),
    .load_regfile(load_regfile), .load_mar(load_mar), .load_mdr(load_mdr),
    .load_data_out(load_data_out), .pcmux_sel(pcmux_sel),
    .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
    .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel),
    .cmpmux_sel(cmpmux_sel), .aluop(aluop), .cmpop(cmpop),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable)
  );

  assign out_v = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
                  pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel,
                  cmpmux_sel, aluop, cmpop, mem_read, mem_write, mem_byte_enable};

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string n, input int k, input logic [6:0] op,
                     input logic [2:0] f3, input logic [6:0] f7,
                     input logic [3:0] aux, input bit fr);
    row_t r;
    r.name = n; r.kind = k; r.op = op; r.f3 = f3; r.f7 = f7; r.aux = aux; r.free = fr;
    rows.push_back(r);
  endtask

  function automatic int find(input string n);
    foreach (rows[i]) if (rows[i].name == n) return i;
    return 0;
  endfunction

  function automatic ctl_t dflt(input logic [2:0] f3);
    ctl_t v;
    v = '0;
    v.aluop = A_ADD;
    v.cmpop = f3;
    v.mbe = 4'hF;
    return v;
  endfunction

  // Lanes covered by an access of n bytes at addr, aligned down to its size
  function automatic logic [3:0] lanes(input int n, input logic [31:0] addr);
    logic [3:0] m;
    int off;
    off = int'(addr[1:0]) & ~(n - 1);
    m = '0;
    for (int i = 0; i < 4; i++) m[i] = (i >= off) && (i < off + n);
    return m;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] exp);
    checks++;
    assert (out_v === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, out_v, exp);
    end
  endtask

  task automatic push(input ctl_t v, input logic resp);
    exp_q.push_back(W'(v));
    resp_q.push_back(resp);
  endtask

  // One cycle: drive mem_resp at the negedge, check, advance to next negedge
  task automatic step(input string tag, input logic [W-1:0] exp, input logic resp);
    mem_resp = resp;
    #1;
    check(tag, exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run one instruction from FETCH1. fw/mw are extra memory wait cycles.
  // abort_at >= 0 pulses reset instead of running that cycle.
  task automatic run_instr(input int idx, input logic [6:0] f7, input int fw,
                           input int mw, input logic br, input logic [31:0] addr,
                           input int abort_at);
    row_t r;
    ctl_t d, v;
    int k;
    r = rows[idx];
    opcode = r.op; funct3 = r.f3; funct7 = f7; br_en = br; mem_address = addr;
    rs1 = 5'($urandom); rs2 = 5'($urandom);
    exp_q.delete(); resp_q.delete();
    d = dflt(r.f3);
    v = d; v.ld_mar = 1; push(v, 1'($urandom_range(0, 1)));
    for (int i = 0; i <= fw; i++) begin
      v = d; v.mrd = 1; v.ld_mdr = 1; push(v, i == fw);
    end
    v = d; v.ld_ir = 1; push(v, 1'($urandom_range(0, 1)));
    push(d, 1'($urandom_range(0, 1)));
    v = d;
    case (r.kind)
      K_LUI:   begin v.rfmux = 2; v.ld_rf = 1; v.ld_pc = 1; end
      K_AUIPC: begin v.am1 = 1; v.am2 = 1; v.ld_rf = 1; v.ld_pc = 1; end
      K_IALU, K_RALU: begin
        v.aluop = r.aux[2:0]; v.ld_rf = 1; v.ld_pc = 1;
        if (r.kind == K_RALU) v.am2 = 5;
      end
      K_ISLT, K_RSLT: begin
        v.cmpop = r.aux[2:0]; v.rfmux = 1; v.ld_rf = 1; v.ld_pc = 1;
        if (r.kind == K_ISLT) v.cmpmux = 1; else v.am2 = 5;
      end
      K_BR:   begin v.am1 = 1; v.am2 = 2; v.ld_pc = 1; v.pcmux = br ? 2'd1 : 2'd0; end
      K_JAL:  begin v.rfmux = 4; v.am1 = 1; v.am2 = 4; v.pcmux = 1; v.ld_rf = 1; v.ld_pc = 1; end
      K_JALR: begin v.rfmux = 4; v.pcmux = 2; v.ld_rf = 1; v.ld_pc = 1; end
      K_LD: begin
        v.marmux = 1; v.ld_mar = 1; push(v, 1'($urandom_range(0, 1)));
        for (int i = 0; i <= mw; i++) begin
          v = d; v.mrd = 1; v.ld_mdr = 1; push(v, i == mw);
        end
        v = d; v.rfmux = r.aux; v.ld_rf = 1; v.ld_pc = 1;
      end
      K_ST: begin
        v.am2 = 3; v.marmux = 1; v.ld_mar = 1; v.ld_dout = 1;
        push(v, 1'($urandom_range(0, 1)));
        for (int i = 0; i <= mw; i++) begin
          v = d; v.mwr = 1; v.mbe = lanes(int'(r.aux), addr); push(v, i == mw);
        end
        v = d; v.ld_pc = 1;
      end
      default: ;
    endcase
    if (r.kind != K_ILL) push(v, 1'($urandom_range(0, 1)));
    k = 0;
    while (exp_q.size() > 0) begin
      if (k == abort_at) begin
        mem_resp = 1'b0;
        #2 rst = 1'b0;
        #1 check($sformatf("%s_rst_now", r.name), W'(dflt(r.f3)));
        @(posedge clk);
        @(negedge clk);
        check($sformatf("%s_rst_held", r.name), W'(dflt(r.f3)));
        rst = 1'b1;
        exp_q.delete(); resp_q.delete();
      end else begin
        step($sformatf("%s#%0d", r.name, k), exp_q.pop_front(), resp_q.pop_front());
        k++;
      end
    end
  endtask

  initial begin
    int idx;
    logic [6:0] f7;
    checks = 0; failures = 0;
    rst = 1'b0; opcode = '0; funct3 = 3'b101; funct7 = '0; br_en = 1'b0;
    rs1 = '0; rs2 = '0; mem_address = '0; mem_resp = 1'b0;

    add("lui",   K_LUI,   7'h37, 3'd0, 7'h00, 4'd0, 1);
    add("auipc", K_AUIPC, 7'h17, 3'd0, 7'h00, 4'd0, 1);
    add("jal",   K_JAL,   7'h6F, 3'd0, 7'h00, 4'd0, 1);
    add("jalr",  K_JALR,  7'h67, 3'd0, 7'h00, 4'd0, 1);
    add("beq",   K_BR,    7'h63, 3'd0, 7'h00, 4'd0, 1);
    add("bne",   K_BR,    7'h63, 3'd1, 7'h00, 4'd0, 1);
    add("blt",   K_BR,    7'h63, 3'd4, 7'h00, 4'd0, 1);
    add("bge",   K_BR,    7'h63, 3'd5, 7'h00, 4'd0, 1);
    add("bltu",  K_BR,    7'h63, 3'd6, 7'h00, 4'd0, 1);
    add("bgeu",  K_BR,    7'h63, 3'd7, 7'h00, 4'd0, 1);
    add("lb",    K_LD,    7'h03, 3'd0, 7'h00, 4'd7, 1);
    add("lh",    K_LD,    7'h03, 3'd1, 7'h00, 4'd5, 1);
    add("lw",    K_LD,    7'h03, 3'd2, 7'h00, 4'd3, 1);
    add("lbu",   K_LD,    7'h03, 3'd4, 7'h00, 4'd8, 1);
    add("lhu",   K_LD,    7'h03, 3'd5, 7'h00, 4'd6, 1);
    add("sb",    K_ST,    7'h23, 3'd0, 7'h00, 4'd1, 1);
    add("sh",    K_ST,    7'h23, 3'd1, 7'h00, 4'd2, 1);
    add("sw",    K_ST,    7'h23, 3'd2, 7'h00, 4'd4, 1);
    add("addi",  K_IALU,  7'h13, 3'd0, 7'h00, {1'b0, A_ADD}, 1);
    add("slti",  K_ISLT,  7'h13, 3'd2, 7'h00, {1'b0, C_BLT}, 1);
    add("sltiu", K_ISLT,  7'h13, 3'd3, 7'h00, {1'b0, C_BLTU}, 1);
    add("xori",  K_IALU,  7'h13, 3'd4, 7'h00, {1'b0, A_XOR}, 1);
    add("ori",   K_IALU,  7'h13, 3'd6, 7'h00, {1'b0, A_OR}, 1);
    add("andi",  K_IALU,  7'h13, 3'd7, 7'h00, {1'b0, A_AND}, 1);
    add("slli",  K_IALU,  7'h13, 3'd1, 7'h00, {1'b0, A_SLL}, 0);
    add("srli",  K_IALU,  7'h13, 3'd5, 7'h00, {1'b0, A_SRL}, 0);
    add("srai",  K_IALU,  7'h13, 3'd5, 7'h20, {1'b0, A_SRA}, 0);
    add("add",   K_RALU,  7'h33, 3'd0, 7'h00, {1'b0, A_ADD}, 0);
    add("sub",   K_RALU,  7'h33, 3'd0, 7'h20, {1'b0, A_SUB}, 0);
    add("sll",   K_RALU,  7'h33, 3'd1, 7'h00, {1'b0, A_SLL}, 0);
    add("slt",   K_RSLT,  7'h33, 3'd2, 7'h00, {1'b0, C_BLT}, 0);
    add("sltu",  K_RSLT,  7'h33, 3'd3, 7'h00, {1'b0, C_BLTU}, 0);
    add("xor",   K_RALU,  7'h33, 3'd4, 7'h00, {1'b0, A_XOR}, 0);
    add("srl",   K_RALU,  7'h33, 3'd5, 7'h00, {1'b0, A_SRL}, 0);
    add("sra",   K_RALU,  7'h33, 3'd5, 7'h20, {1'b0, A_SRA}, 0);
    add("or",    K_RALU,  7'h33, 3'd6, 7'h00, {1'b0, A_OR}, 0);
    add("and",   K_RALU,  7'h33, 3'd7, 7'h00, {1'b0, A_AND}, 0);
    add("illegal", K_ILL, 7'h73, 3'd0, 7'h00, 4'd0, 1);

    // Reset held three cycles: defaults throughout
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_resp = 1'($urandom_range(0, 1));
      #1 check("reset_hold", W'(dflt(3'b101)));
    end
    @(negedge clk);
    rst = 1'b1;

    // Directed cases
    run_instr(find("addi"), 7'h00, 0, 0, 1'b0, 32'h0, -1);
    run_instr(find("beq"), 7'h00, 0, 0, 1'b1, 32'h0, -1);
    run_instr(find("beq"), 7'h00, 0, 0, 1'b0, 32'h0, -1);
    run_instr(find("lw"), 7'h00, 0, 2, 1'b0, 32'h100, -1);
    run_instr(find("sb"), 7'h00, 0, 0, 1'b0, 32'h1002, -1);
    run_instr(find("sh"), 7'h00, 0, 0, 1'b0, 32'h2006, -1);
    run_instr(find("sb"), 7'h00, 1, 1, 1'b0, 32'h3003, -1);
    run_instr(find("srai"), 7'h20, 0, 0, 1'b0, 32'h0, -1);
    run_instr(find("addi"), 7'h7F, 0, 0, 1'b0, 32'h0, -1);
    run_instr(find("illegal"), 7'h00, 0, 0, 1'b0, 32'h0, -1);
    // Reset in the second LD1 cycle, then a clean restart
    run_instr(find("lw"), 7'h00, 0, 3, 1'b0, 32'h40, 6);
    run_instr(find("add"), 7'h00, 0, 0, 1'b0, 32'h0, -1);

    // Randomized instruction mix with random memory latency
    for (int n = 0; n < 80; n++) begin
      idx = $urandom_range(0, rows.size() - 1);
      f7 = rows[idx].free ? 7'($urandom) : rows[idx].f7;
      run_instr(idx, f7, $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), $urandom, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
